// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and its sequence monitor:
// FSM states, fault codes, lamp patterns and the legal phase order.
package traffic_pkg;

  // Phase states use the same values as the phase output; FAULT reads as phase 0.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RED   = 3'd1,
    ST_GREEN = 3'd2,
    ST_AMBER = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    FC_NONE  = 3'd0,
    FC_MULTI = 3'd1,
    FC_ORDER = 3'd2,
    FC_SHORT = 3'd3,
    FC_LONG  = 3'd4,
    FC_DARK  = 3'd5
  } fault_code_t;

  // Lamp vectors are {red, amber, green}.
  localparam logic [2:0] LAMP_DARK  = 3'b000;
  localparam logic [2:0] LAMP_RED   = 3'b100;
  localparam logic [2:0] LAMP_AMBER = 3'b010;
  localparam logic [2:0] LAMP_GREEN = 3'b001;

  function automatic logic [2:0] lamp_of(input state_t s);
    case (s)
      ST_RED:   lamp_of = LAMP_RED;
      ST_GREEN: lamp_of = LAMP_GREEN;
      ST_AMBER: lamp_of = LAMP_AMBER;
      default:  lamp_of = LAMP_DARK;
    endcase
  endfunction

  function automatic state_t next_phase(input state_t s);
    case (s)
      ST_RED:   next_phase = ST_GREEN;
      ST_GREEN: next_phase = ST_AMBER;
      ST_AMBER: next_phase = ST_RED;
      default:  next_phase = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/tic_counter.sv
// Saturating up-counter with synchronous clear; used for dwell and flash timing.
module tic_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/light_sequence_monitor.sv
// Watches the lamp drives of a traffic-light controller, checks phase order and
// dwell timing in tics, and latches a fault code with a flashing safe-mode output.
module light_sequence_monitor
  import traffic_pkg::*;
#(
  parameter int RED_TICS   = 35,
  parameter int AMBER_TICS = 3,
  parameter int GREEN_TICS = 20,
  parameter int TOL        = 1,
  parameter int FLASH_TICS = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tic,
  input  logic        red,
  input  logic        amber,
  input  logic        green,
  input  logic        clear,
  output logic [1:0]  phase,
  output logic        fault,
  output logic [2:0]  fault_code,
  output logic        flash,
  output logic [15:0] cycles
);

  localparam logic [8:0] RED_SHORT   = 9'(RED_TICS - TOL);
  localparam logic [8:0] RED_LONG    = 9'(RED_TICS + TOL + 1);
  localparam logic [8:0] GREEN_SHORT = 9'(GREEN_TICS - TOL);
  localparam logic [8:0] GREEN_LONG  = 9'(GREEN_TICS + TOL + 1);
  localparam logic [8:0] AMBER_SHORT = 9'(AMBER_TICS - TOL);
  localparam logic [8:0] AMBER_LONG  = 9'(AMBER_TICS + TOL + 1);
  localparam logic [7:0] FLASH_LAST  = 8'(FLASH_TICS - 1);

  state_t      r_state;
  fault_code_t r_code;
  logic        r_fault;
  logic        r_flash;
  logic        r_dark;
  logic [15:0] r_cycles;

  state_t      w_next_state;
  fault_code_t w_new_code;
  logic        w_dark_next;
  logic [2:0]  w_lamps;
  logic        w_multi;
  logic [7:0]  w_dwell;
  logic [7:0]  w_dwell_inc;
  logic [7:0]  w_ftic;
  logic [8:0]  w_short_lim;
  logic [8:0]  w_long_lim;
  logic        w_dwell_short;
  logic        w_dwell_long;
  logic        w_dwell_clr;
  logic        w_flash_wrap;
  logic        w_flash_clr;

  assign w_lamps = {red, amber, green};
  assign w_multi = ($countones(w_lamps) > 1);

  // Dwell as it will stand after this cycle's tic, used for the overstay check.
  assign w_dwell_inc   = (tic && (w_dwell != 8'hFF)) ? (w_dwell + 8'd1) : w_dwell;
  assign w_dwell_short = ({1'b0, w_dwell} < w_short_lim);
  assign w_dwell_long  = ({1'b0, w_dwell_inc} >= w_long_lim);

  always_comb begin
    w_short_lim = 9'd0;
    w_long_lim  = 9'h1FF;
    case (r_state)
      ST_RED:   begin w_short_lim = RED_SHORT;   w_long_lim = RED_LONG;   end
      ST_GREEN: begin w_short_lim = GREEN_SHORT; w_long_lim = GREEN_LONG; end
      ST_AMBER: begin w_short_lim = AMBER_SHORT; w_long_lim = AMBER_LONG; end
      default:  begin w_short_lim = 9'd0;        w_long_lim = 9'h1FF;     end
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_new_code   = FC_NONE;
    w_dark_next  = 1'b0;
    case (r_state)
      ST_FAULT: begin
        if (clear) w_next_state = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_multi) begin
          w_next_state = ST_FAULT;
          w_new_code   = FC_MULTI;
        end else if (w_lamps == LAMP_RED) begin
          w_next_state = ST_RED;
        end
      end
      default: begin
        if (w_multi) begin
          w_next_state = ST_FAULT;
          w_new_code   = FC_MULTI;
        end else if (w_lamps == LAMP_DARK) begin
          // One dark tic is forgiven; the second one is a fault.
          w_dark_next = r_dark | tic;
          if (tic && r_dark) begin
            w_next_state = ST_FAULT;
            w_new_code   = FC_DARK;
          end else if (w_dwell_long) begin
            w_next_state = ST_FAULT;
            w_new_code   = FC_LONG;
          end
        end else if (w_lamps == lamp_of(r_state)) begin
          if (w_dwell_long) begin
            w_next_state = ST_FAULT;
            w_new_code   = FC_LONG;
          end
        end else if (w_lamps == lamp_of(next_phase(r_state))) begin
          if (w_dwell_short) begin
            w_next_state = ST_FAULT;
            w_new_code   = FC_SHORT;
          end else begin
            w_next_state = next_phase(r_state);
          end
        end else begin
          w_next_state = ST_FAULT;
          w_new_code   = FC_ORDER;
        end
      end
    endcase
  end

  // A tic coinciding with a phase change is dropped, so the new phase starts at 0.
  assign w_dwell_clr  = (w_next_state != r_state) || (r_state == ST_IDLE) || (r_state == ST_FAULT);
  assign w_flash_wrap = (r_state == ST_FAULT) && tic && (w_ftic == FLASH_LAST);
  assign w_flash_clr  = (r_state != ST_FAULT) || w_flash_wrap;

  tic_counter #(.W(8)) u_dwell (
    .clock   (clock),
    .reset   (reset),
    .i_en    (tic),
    .i_clr   (w_dwell_clr),
    .o_count (w_dwell)
  );

  tic_counter #(.W(8)) u_flash (
    .clock   (clock),
    .reset   (reset),
    .i_en    (tic),
    .i_clr   (w_flash_clr),
    .o_count (w_ftic)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_code   <= FC_NONE;
      r_fault  <= 1'b0;
      r_flash  <= 1'b0;
      r_dark   <= 1'b0;
      r_cycles <= 16'd0;
    end else begin
      r_state <= w_next_state;
      r_dark  <= w_dark_next;
      if ((w_next_state == ST_FAULT) && (r_state != ST_FAULT)) begin
        r_fault <= 1'b1;
        r_code  <= w_new_code;
        r_flash <= 1'b1;
      end else if ((r_state == ST_FAULT) && clear) begin
        r_fault <= 1'b0;
        r_code  <= FC_NONE;
        r_flash <= 1'b0;
      end else if (w_flash_wrap) begin
        r_flash <= ~r_flash;
      end
      if ((r_state == ST_AMBER) && (w_next_state == ST_RED)) begin
        r_cycles <= r_cycles + 16'd1;
      end
    end
  end

  assign phase      = r_state[1:0];
  assign fault      = r_fault;
  assign fault_code = r_code;
  assign flash      = r_flash;
  assign cycles     = r_cycles;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Bench for light_sequence_monitor: scripted table of phase segments, a flash and
// reset sequence, then randomized lamp traffic checked against a rule-level model.
module tb_light_sequence_monitor;

  localparam int RED_N   = 35;
  localparam int AMBER_N = 3;
  localparam int GREEN_N = 20;
  localparam int TOL     = 1;
  localparam int FLASH_N = 2;
  localparam int N_RAND  = 6000;

  localparam logic [2:0] L_D  = 3'b000;
  localparam logic [2:0] L_R  = 3'b100;
  localparam logic [2:0] L_A  = 3'b010;
  localparam logic [2:0] L_G  = 3'b001;
  localparam logic [2:0] L_RG = 3'b101;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tic   = 1'b0;
  logic        red   = 1'b0;
  logic        amber = 1'b0;
  logic        green = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  phase;
  logic        fault;
  logic [2:0]  fault_code;
  logic        flash;
  logic [15:0] cycles;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 red, 2 green, 3 amber, 4 fault
  int m_ph, m_dwell, m_dark, m_code, m_flash, m_ftic, m_cycles;

  light_sequence_monitor #(
    .RED_TICS(RED_N), .AMBER_TICS(AMBER_N), .GREEN_TICS(GREEN_N),
    .TOL(TOL), .FLASH_TICS(FLASH_N)
  ) dut (
    .clock(clock), .reset(reset), .tic(tic), .red(red), .amber(amber),
    .green(green), .clear(clear), .phase(phase), .fault(fault),
    .fault_code(fault_code), .flash(flash), .cycles(cycles)
  );

  always #5 clock = ~clock;

  function automatic int dwell_n(input int ph);
    case (ph)
      1: return RED_N;
      2: return GREEN_N;
      3: return AMBER_N;
      default: return 0;
    endcase
  endfunction

  function automatic logic [2:0] lamp_of(input int ph);
    case (ph)
      1: return L_R;
      2: return L_G;
      3: return L_A;
      default: return L_D;
    endcase
  endfunction

  function automatic int next_of(input int ph);
    return (ph == 3) ? 1 : ph + 1;
  endfunction

  task automatic model_reset();
    m_ph = 0; m_dwell = 0; m_dark = 0; m_code = 0;
    m_flash = 0; m_ftic = 0; m_cycles = 0;
  endtask

  task automatic enter_fault(input int code);
    m_ph = 4; m_code = code; m_flash = 1; m_ftic = 0;
  endtask

  task automatic bump_dwell();
    if (m_dwell < 255) m_dwell++;
    if (m_dwell >= dwell_n(m_ph) + TOL + 1) enter_fault(4);
  endtask

  task automatic model_step(input logic [2:0] l, input logic t, input logic c);
    if (m_ph == 4) begin
      if (c) begin
        m_ph = 0; m_dwell = 0; m_code = 0; m_flash = 0; m_dark = 0;
      end else if (t) begin
        m_ftic++;
        if (m_ftic == FLASH_N) begin
          m_flash = 1 - m_flash;
          m_ftic = 0;
        end
      end
    end else if ($countones(l) > 1) begin
      enter_fault(1);
    end else if (m_ph == 0) begin
      if (l == L_R) begin
        m_ph = 1; m_dwell = 0; m_dark = 0;
      end
    end else if (l == L_D) begin
      if (t) begin
        m_dark++;
        if (m_dark >= 2) enter_fault(5);
        else bump_dwell();
      end
    end else begin
      m_dark = 0;
      if (l == lamp_of(m_ph)) begin
        if (t) bump_dwell();
      end else if (l == lamp_of(next_of(m_ph))) begin
        if (m_dwell < dwell_n(m_ph) - TOL) begin
          enter_fault(3);
        end else begin
          if (m_ph == 3) m_cycles = (m_cycles + 1) % 65536;
          m_ph = next_of(m_ph);
          m_dwell = 0;
        end
      end else begin
        enter_fault(2);
      end
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    int e_ph;
    e_ph = (m_ph == 4) ? 0 : m_ph;
    checks++;
    if (int'(phase) != e_ph || int'(fault) != int'(m_ph == 4) || int'(fault_code) != m_code ||
        int'(flash) != m_flash || int'(cycles) != m_cycles) begin
      errors++;
      $display("FAIL model %s: got ph=%0d f=%0d code=%0d flash=%0d cyc=%0d, expected ph=%0d f=%0d code=%0d flash=%0d cyc=%0d",
               tag, phase, fault, fault_code, flash, cycles,
               e_ph, (m_ph == 4), m_code, m_flash, m_cycles);
    end
  endtask

  task automatic step(input logic [2:0] l, input logic t, input logic c, input string tag);
    {red, amber, green} = l;
    tic = t;
    clear = c;
    @(posedge clock);
    model_step(l, t, c);
    #1;
    compare_model(tag);
  endtask

  typedef struct {
    logic [2:0]  lamps;
    int          n;
    logic        clr;
    logic [1:0]  ph;
    logic        flt;
    logic [2:0]  code;
    logic [15:0] cyc;
  } row_t;

  function automatic row_t mk(input logic [2:0] l, input int n, input logic clr, input logic [1:0] ph,
                              input logic flt, input logic [2:0] code, input logic [15:0] cyc);
    row_t r;
    r.lamps = l; r.n = n; r.clr = clr; r.ph = ph; r.flt = flt; r.code = code; r.cyc = cyc;
    return r;
  endfunction

  task automatic run_row(input int idx, input row_t r);
    step(r.lamps, 1'b0, r.clr, $sformatf("row%0d_entry", idx));
    for (int k = 0; k < r.n; k++) step(r.lamps, 1'b1, 1'b0, $sformatf("row%0d_tic%0d", idx, k));
    check_val($sformatf("row%0d_phase", idx), int'(phase), int'(r.ph));
    check_val($sformatf("row%0d_fault", idx), int'(fault), int'(r.flt));
    check_val($sformatf("row%0d_code", idx), int'(fault_code), int'(r.code));
    check_val($sformatf("row%0d_cycles", idx), int'(cycles), int'(r.cyc));
    $display("row %0d lamps=%b n=%0d clr=%0d -> phase=%0d fault=%0d code=%0d cycles=%0d",
             idx, r.lamps, r.n, r.clr, phase, fault, fault_code, cycles);
  endtask

  row_t rows[$];
  row_t tail[$];

  initial begin
    model_reset();
    // Nominal two cycles, then a multi-lamp glitch mid-RED
    rows.push_back(mk(L_R, 35, 0, 2'd1, 0, 3'd0, 16'd0));
    rows.push_back(mk(L_G, 20, 0, 2'd2, 0, 3'd0, 16'd0));
    rows.push_back(mk(L_A,  3, 0, 2'd3, 0, 3'd0, 16'd0));
    rows.push_back(mk(L_R, 35, 0, 2'd1, 0, 3'd0, 16'd1));
    rows.push_back(mk(L_G, 20, 0, 2'd2, 0, 3'd0, 16'd1));
    rows.push_back(mk(L_A,  3, 0, 2'd3, 0, 3'd0, 16'd1));
    rows.push_back(mk(L_R, 10, 0, 2'd1, 0, 3'd0, 16'd2));
    rows.push_back(mk(L_RG, 0, 0, 2'd0, 1, 3'd1, 16'd2));
    // After the flash sequence: clear, short green, long amber, illegal order, dark
    tail.push_back(mk(L_D,  0, 1, 2'd0, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_R, 35, 0, 2'd1, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_G, 18, 0, 2'd2, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_A,  0, 0, 2'd0, 1, 3'd3, 16'd2));
    tail.push_back(mk(L_D,  0, 1, 2'd0, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_R, 35, 0, 2'd1, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_G, 21, 0, 2'd2, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_A,  0, 0, 2'd3, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_A,  4, 0, 2'd3, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_A,  1, 0, 2'd0, 1, 3'd4, 16'd2));
    tail.push_back(mk(L_D,  0, 1, 2'd0, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_R, 35, 0, 2'd1, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_A,  0, 0, 2'd0, 1, 3'd2, 16'd2));
    tail.push_back(mk(L_D,  0, 1, 2'd0, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_R,  5, 0, 2'd1, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_D,  1, 0, 2'd1, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_R,  1, 0, 2'd1, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_D,  2, 0, 2'd0, 1, 3'd5, 16'd2));
    tail.push_back(mk(L_D,  0, 1, 2'd0, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_R, 35, 0, 2'd1, 0, 3'd0, 16'd2));
    tail.push_back(mk(L_G, 10, 0, 2'd2, 0, 3'd0, 16'd2));

    repeat (3) @(posedge clock);
    #2;
    compare_model("reset_held");
    reset = 1'b0;
    $display("reset released: phase=%0d fault=%0d cycles=%0d", phase, fault, cycles);

    for (int i = 0; i < rows.size(); i++) run_row(i, rows[i]);

    // Flash starts at 1 on entry and toggles every FLASH_N tics
    for (int k = 1; k <= 8; k++) begin
      step(L_R, 1'b1, 1'b0, $sformatf("flash_tic%0d", k));
      check_val($sformatf("flash_tic%0d", k), int'(flash), ((k / FLASH_N) % 2 == 0) ? 1 : 0);
      check_val($sformatf("flash_code_tic%0d", k), int'(fault_code), 1);
      $display("flash tic %0d flash=%0d code=%0d", k, flash, fault_code);
    end

    for (int i = 0; i < tail.size(); i++) run_row(rows.size() + i, tail[i]);

    // Asynchronous reset mid-GREEN clears outputs before any clock edge
    #2;
    reset = 1'b1;
    #1;
    check_val("async_rst_phase", int'(phase), 0);
    check_val("async_rst_fault", int'(fault), 0);
    check_val("async_rst_code", int'(fault_code), 0);
    check_val("async_rst_flash", int'(flash), 0);
    check_val("async_rst_cycles", int'(cycles), 0);
    $display("async reset: phase=%0d fault=%0d code=%0d flash=%0d cycles=%0d",
             phase, fault, fault_code, flash, cycles);
    model_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    step(L_R, 1'b0, 1'b0, "post_reset_red");
    check_val("post_reset_phase", int'(phase), 1);
    check_val("post_reset_cycles", int'(cycles), 0);
    $display("post reset red: phase=%0d cycles=%0d", phase, cycles);

    begin
      int seg = 1;
      int seg_tics = 0;
      int target = RED_N;
      int prev_ph;
      logic [2:0] l;
      logic t, c;
      for (int n = 0; n < N_RAND; n++) begin
        int r;
        r = int'($urandom_range(0, 999));
        t = ($urandom_range(0, 2) == 0);
        c = 1'b0;
        if (m_ph == 4) begin
          c = ($urandom_range(0, 9) < 2);
          l = 3'($urandom_range(0, 7));
          seg = 1; seg_tics = 0; target = RED_N + int'($urandom_range(0, 4)) - 2;
        end else if (m_ph == 0) begin
          l = L_R;
          seg = 1; seg_tics = 0; target = RED_N + int'($urandom_range(0, 4)) - 2;
        end else begin
          c = ($urandom_range(0, 99) == 0);
          if (r < 2) l = (r == 0) ? 3'b110 : 3'b011;
          else if (r < 6) l = L_D;
          else if (r < 8) l = 3'($urandom_range(1, 7));
          else begin
            if (seg_tics >= target) begin
              seg = next_of(seg);
              seg_tics = 0;
              target = dwell_n(seg) + int'($urandom_range(0, 4)) - 2;
            end else if (t) begin
              seg_tics++;
            end
            l = lamp_of(seg);
          end
        end
        prev_ph = m_ph;
        step(l, t, c, $sformatf("rand%0d", n));
        if (m_ph != prev_ph)
          $display("rand %0d lamps=%b tic=%0d clr=%0d phase %0d->%0d code=%0d cycles=%0d",
                   n, l, t, c, prev_ph, m_ph, m_code, m_cycles);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_sequence_monitor.md
LIGHT_SEQUENCE_MONITOR -- requirements
Module: light_sequence_monitor

Interface
REQ-001 The module SHALL have parameter RED_TICS, default 35, required red dwell in tics.
REQ-002 The module SHALL have parameter AMBER_TICS, default 3, required amber dwell in tics.
REQ-003 The module SHALL have parameter GREEN_TICS, default 20, required green dwell in tics.
REQ-004 The module SHALL have parameter TOL, default 1, allowed dwell deviation in tics (either side).
REQ-005 The module SHALL have parameter FLASH_TICS, default 2, half-period of the fault flash in tics.
REQ-006 Port clock, input, 1 bit: the single clock.
REQ-007 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 Port tic, input, 1 bit: one-cycle time-unit strobe; all dwell/flash timing counts tic cycles only.
REQ-009 Port red, amber, green, inputs, 1 bit each: lamp drives from the upstream traffic-light controller (1 = on).
REQ-010 Port clear, input, 1 bit: synchronous pulse that leaves FAULT.
REQ-011 Port phase, output, 2 bits: 0 IDLE, 1 RED, 2 GREEN, 3 AMBER; FAULT reports 0.
REQ-012 Port fault, output, 1 bit: high while in FAULT.
REQ-013 Port fault_code, output, 3 bits: 0 none, 1 multiple lamps, 2 illegal order, 3 dwell short, 4 dwell long, 5 dark.
REQ-014 Port flash, output, 1 bit: safe-mode amber flash, toggling only in FAULT.
REQ-015 Port cycles, output, 16 bits: count of completed red-green-amber cycles.

Function
REQ-016 The state machine SHALL have states IDLE, RED, GREEN, AMBER and FAULT; all inputs are sampled on the rising edge of clock.
REQ-017 lamps = {red, amber, green}; more than one bit set in any cycle SHALL enter FAULT with code 1, overriding all other checks.
REQ-018 IDLE SHALL enter RED on the first cycle with red alone lit; any other single lamp SHALL be ignored in IDLE.
REQ-019 Legal transitions SHALL be RED->GREEN, GREEN->AMBER and AMBER->RED, each taken on the cycle the new lamp is alone lit.
REQ-020 Any other single-lamp change SHALL enter FAULT with code 2.
REQ-021 An 8-bit dwell counter SHALL reset to 0 on phase entry, increment on each tic in the phase, and saturate at 255.
REQ-022 On a legal transition with dwell < N-TOL, where N is the leaving phase's TICS parameter, the block SHALL enter FAULT with code 3 instead of the transition.
REQ-023 When dwell reaches N+TOL+1 without a transition, the block SHALL enter FAULT with code 4 on that cycle.
REQ-024 All lamps off SHALL be tolerated for at most 1 tic while the current phase is held; on the second dark tic the block SHALL enter FAULT with code 5.
REQ-025 AMBER->RED SHALL increment cycles, wrapping modulo 2^16.
REQ-026 fault_code SHALL latch on FAULT entry and hold until clear; it is 0 outside FAULT.
REQ-027 In FAULT, flash SHALL start at 1 and toggle every FLASH_TICS tics; outside FAULT, flash SHALL be 0.
REQ-028 clear in FAULT SHALL go to IDLE next cycle, zero dwell and keep cycles; clear outside FAULT SHALL be ignored.
REQ-029 A simultaneous tic and transition SHALL count into the new phase as dwell = 0, i.e. the tic is not counted.
REQ-030 Outputs SHALL be registered, with one cycle of latency from the sampled input.

Reset
REQ-031 Asserting reset SHALL immediately force IDLE, phase 0, fault 0, fault_code 0, flash 0, cycles 0 and dwell 0, including mid-phase or in FAULT.
REQ-032 After reset deasserts, the first rising clock edge SHALL evaluate inputs normally.

Structure
REQ-033 The state encoding and fault-code constants SHALL live in shared package traffic_pkg, for reuse by the controller.
REQ-034 The block SHALL contain one sub-module, tic_counter (enable, clear, saturating count), instanced for dwell and flash timing.

Verification
REQ-035 Nominal: red 35, green 20, amber 3 tics for two cycles -> no fault, cycles = 2, phase sequence 1,2,3,1.
REQ-036 Red and green both lit for one cycle mid-RED -> fault 1, fault_code 1, flash toggles every 2 tics.
REQ-037 Green dwell 18 tics then amber -> fault_code 3; green dwell 21 tics then amber -> no fault.
REQ-038 Amber held 5 tics -> fault_code 4 on the cycle dwell reaches 5.
REQ-039 RED->AMBER direct -> fault_code 2; then clear -> IDLE, fault 0, cycles unchanged.
REQ-040 Reset asserted at green dwell 10 -> all outputs 0 immediately; a new red starts in IDLE->RED.
